// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the Mini-SRC sequencer: FSM states, branch opcode,
// C2 condition encodings and IR field positions.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, DEC, T3, T4, T5, T6, EXEC
  } state_e;

  localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;

  // Branch condition field, evaluated by the CON flip-flop in the datapath
  typedef enum logic [1:0] {
    C2_ZERO    = 2'b00,
    C2_NONZERO = 2'b01,
    C2_PLUS    = 2'b10,
    C2_MINUS   = 2'b11
  } c2_e;

  localparam int IR_OPC_HI = 31;
  localparam int IR_OPC_LO = 27;
  localparam int IR_RA_HI  = 26;
  localparam int IR_RA_LO  = 23;
  localparam int IR_C2_HI  = 20;
  localparam int IR_C2_LO  = 19;
  localparam int IR_C_HI   = 18;
  localparam int IR_C_LO   = 0;

endpackage

// File: rtl/branch_stats.sv
// Taken / not-taken branch counters, saturating at all-ones.
// Only instantiated when BRANCH_STATS_EN is defined.
module branch_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc_taken,
  input  logic             inc_not_taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] not_taken_q, not_taken_d;

  always_comb begin
    taken_d     = taken_q;
    not_taken_d = not_taken_q;
    if (inc_taken && (taken_q != '1))
      taken_d = taken_q + CNT_W'(1);
    if (inc_not_taken && (not_taken_q != '1))
      not_taken_d = not_taken_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      taken_q     <= '0;
      not_taken_q <= '0;
    end else begin
      taken_q     <= taken_d;
      not_taken_q <= not_taken_d;
    end
  end

  assign taken_cnt     = taken_q;
  assign not_taken_cnt = not_taken_q;

endmodule

// File: rtl/branch_sequencer.sv
// Moore control FSM for the Mini-SRC 1-bus datapath: instruction fetch, conditional
// branch sequencing through CON, executor handshake. BRANCH_STATS_EN adds branch counters.
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] BR_OPCODE = BR_OPCODE_DEF
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        exec_done,
  output logic        pc_out,
  output logic        mar_in,
  output logic        inc_pc,
  output logic        z_in,
  output logic        zlow_out,
  output logic        pc_in,
  output logic        read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        gra,
  output logic        r_out,
  output logic        con_in,
  output logic        y_in,
  output logic        c_out,
  output logic        alu_add,
  output logic        exec_req,
  output logic        busy
`ifdef BRANCH_STATS_EN
  , output logic [CNT_W-1:0] taken_cnt
  , output logic [CNT_W-1:0] not_taken_cnt
`endif
);

  state_e state_q, state_d;
  logic   t1_wait_q, t1_wait_d;
  logic   is_branch;
  logic   act;
  logic   ir_unused;

  assign is_branch = (ir[IR_OPC_HI:IR_OPC_LO] == BR_OPCODE);
  assign ir_unused = ^ir[IR_RA_HI:IR_C_LO];
  assign act       = ~clr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = run ? T0 : IDLE;
      T0:      state_d = T1;
      T1:      state_d = mem_ready ? T2 : T1;
      T2:      state_d = DEC;
      DEC:     state_d = is_branch ? T3 : EXEC;
      T3:      state_d = T4;
      T4:      state_d = T5;
      T5:      state_d = T6;
      T6:      state_d = run ? T0 : IDLE;
      EXEC:    state_d = exec_done ? (run ? T0 : IDLE) : EXEC;
      default: state_d = IDLE;
    endcase
  end

  // Marks T1 wait cycles so the PC write happens only on the first T1 cycle
  assign t1_wait_d = (state_q == T1) && !mem_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  always_comb begin
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    read     = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    gra      = 1'b0;
    r_out    = 1'b0;
    con_in   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    exec_req = 1'b0;
    busy     = act && (state_q != IDLE);
    if (act) begin
      unique case (state_q)
        T0: begin
          pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        end
        T1: begin
          zlow_out = !t1_wait_q; pc_in = !t1_wait_q;
          read = 1'b1; mdr_in = 1'b1;
        end
        T2: begin
          mdr_out = 1'b1; ir_in = 1'b1;
        end
        T3: begin
          gra = 1'b1; r_out = 1'b1; con_in = 1'b1;
        end
        T4: begin
          pc_out = 1'b1; y_in = 1'b1;
        end
        T5: begin
          c_out = 1'b1; alu_add = 1'b1; z_in = 1'b1;
        end
        T6: begin
          zlow_out = 1'b1; pc_in = con;
        end
        EXEC:    exec_req = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  branch_stats #(.CNT_W(CNT_W)) u_stats (
    .clk           (clk),
    .clr           (clr),
    .inc_taken     (act && (state_q == T6) && con),
    .inc_not_taken (act && (state_q == T6) && !con),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
  );
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with a tiny PC/Y/Z/CON datapath model driven by the strobes.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        clr, run, mem_ready, con, exec_done;
  logic [31:0] ir;
  logic        pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in;
  logic        gra, r_out, con_in, y_in, c_out, alu_add, exec_req, busy;
`ifdef BRANCH_STATS_EN
  logic [2:0]  taken_cnt, not_taken_cnt;
`endif

  always #5 clk = ~clk;

  branch_sequencer #(
    .BR_OPCODE (5'b10010)
`ifdef BRANCH_STATS_EN
    , .CNT_W (3)
`endif
  ) dut (
    .clk (clk), .clr (clr), .run (run), .mem_ready (mem_ready), .ir (ir), .con (con),
    .exec_done (exec_done),
    .pc_out (pc_out), .mar_in (mar_in), .inc_pc (inc_pc), .z_in (z_in), .zlow_out (zlow_out),
    .pc_in (pc_in), .read (read), .mdr_in (mdr_in), .mdr_out (mdr_out), .ir_in (ir_in),
    .gra (gra), .r_out (r_out), .con_in (con_in), .y_in (y_in), .c_out (c_out),
    .alu_add (alu_add), .exec_req (exec_req), .busy (busy)
`ifdef BRANCH_STATS_EN
    , .taken_cnt (taken_cnt), .not_taken_cnt (not_taken_cnt)
`endif
  );

  logic [17:0] outv;
  assign outv = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in,
                 gra, r_out, con_in, y_in, c_out, alu_add, exec_req, busy};

  localparam logic [17:0] M_PC_OUT = 18'd1 << 17, M_MAR_IN = 18'd1 << 16, M_INC_PC = 18'd1 << 15;
  localparam logic [17:0] M_Z_IN = 18'd1 << 14, M_ZLOW = 18'd1 << 13, M_PC_IN = 18'd1 << 12;
  localparam logic [17:0] M_READ = 18'd1 << 11, M_MDR_IN = 18'd1 << 10, M_MDR_OUT = 18'd1 << 9;
  localparam logic [17:0] M_IR_IN = 18'd1 << 8, M_GRA = 18'd1 << 7, M_R_OUT = 18'd1 << 6;
  localparam logic [17:0] M_CON_IN = 18'd1 << 5, M_Y_IN = 18'd1 << 4, M_C_OUT = 18'd1 << 3;
  localparam logic [17:0] M_ADD = 18'd1 << 2, M_EXREQ = 18'd1 << 1, M_BUSY = 18'd1;

  localparam logic [17:0] E_IDLE = 18'd0;
  localparam logic [17:0] E_T0   = M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN | M_BUSY;
  localparam logic [17:0] E_T1   = M_ZLOW | M_PC_IN | M_READ | M_MDR_IN | M_BUSY;
  localparam logic [17:0] E_T1W  = M_READ | M_MDR_IN | M_BUSY;
  localparam logic [17:0] E_T2   = M_MDR_OUT | M_IR_IN | M_BUSY;
  localparam logic [17:0] E_DEC  = M_BUSY;
  localparam logic [17:0] E_T3   = M_GRA | M_R_OUT | M_CON_IN | M_BUSY;
  localparam logic [17:0] E_T4   = M_PC_OUT | M_Y_IN | M_BUSY;
  localparam logic [17:0] E_T5   = M_C_OUT | M_ADD | M_Z_IN | M_BUSY;
  localparam logic [17:0] E_T6T  = M_ZLOW | M_PC_IN | M_BUSY;
  localparam logic [17:0] E_T6N  = M_ZLOW | M_BUSY;
  localparam logic [17:0] E_EX   = M_EXREQ | M_BUSY;

  // Datapath model: PC, Y, Z, CON and register R2 (the only Ra used here)
  logic        mdl_rst;
  logic [31:0] pc_m, y_m, z_m, r2_m;
  logic        con_m;

  function automatic logic cond_f(input logic [31:0] v, input logic [1:0] c2);
    case (c2)
      2'b00:   return v == 32'd0;
      2'b01:   return v != 32'd0;
      2'b10:   return !v[31];
      default: return v[31];
    endcase
  endfunction

  always @(posedge clk) begin
    if (mdl_rst) begin
      pc_m  <= 32'h10;
      y_m   <= 32'h0;
      z_m   <= 32'h0;
      con_m <= 1'b0;
    end else begin
      if (pc_out && inc_pc && z_in) z_m <= pc_m + 32'd1;
      if (c_out && alu_add && z_in) z_m <= y_m + {{13{ir[18]}}, ir[18:0]};
      if (pc_out && y_in)           y_m <= pc_m;
      if (zlow_out && pc_in)        pc_m <= z_m;
      if (gra && r_out && con_in)   con_m <= cond_f(r2_m, ir[20:19]);
    end
  end
  assign con = con_m;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [17:0] exp, input string tag);
    @(posedge clk);
    @(negedge clk);
    chk(tag, {14'd0, outv}, {14'd0, exp});
  endtask

  // Starts in T0 (already checked), ends in DEC
  task automatic fetch(input int waits);
    step(E_T1, "t1");
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      step(E_T1W, "t1_wait");
    end
    mem_ready = 1'b1;
    step(E_T2, "t2");
    mem_ready = 1'b0;
    step(E_DEC, "dec");
  endtask

  // Starts in DEC with a branch IR, ends in T0 or IDLE
  task automatic branch(input logic exp_taken, input logic nxt_run);
    step(E_T3, "t3");
    step(E_T4, "t4");
    step(E_T5, "t5");
    step(exp_taken ? E_T6T : E_T6N, "t6");
    run = nxt_run;
    step(nxt_run ? E_T0 : E_IDLE, "t6_exit");
    run = 1'b1;
  endtask

  initial begin
    mdl_rst = 1'b1; clr = 1'b1; run = 1'b0; mem_ready = 1'b0;
    ir = 32'h0; exec_done = 1'b0; r2_m = 32'h0;
    @(negedge clk);
    mdl_rst = 1'b0;
    step(E_IDLE, "rst_idle");
    run = 1'b1; mem_ready = 1'b1;
    step(E_IDLE, "rst_hold_run");
    clr = 1'b0;
    step(E_T0, "clr_rel_t0");

    // brzr R2,35 taken then not taken
    ir = 32'h9100_0023; r2_m = 32'd0;
    fetch(0);
    branch(1'b1, 1'b1);
    chk("brzr_taken_pc", pc_m, 32'h34);
    r2_m = 32'd5;
    fetch(0);
    branch(1'b0, 1'b0);
    chk("brzr_nt_pc", pc_m, 32'h35);

    // brnz taken with R2=-1, brmi not taken with R2=0
    ir = 32'h9108_0023; r2_m = 32'hFFFF_FFFF;
    step(E_T0, "brnz_t0");
    fetch(0);
    branch(1'b1, 1'b0);
    chk("brnz_taken_pc", pc_m, 32'h59);
    ir = 32'h9118_0023; r2_m = 32'd0;
    step(E_T0, "brmi_t0");
    fetch(0);
    branch(1'b0, 1'b0);
    chk("brmi_nt_pc", pc_m, 32'h5A);

    // brpl with three memory wait states
    ir = 32'h9110_0023;
    step(E_T0, "brpl_t0");
    fetch(3);
    chk("wait_pc_once", pc_m, 32'h5B);
    branch(1'b1, 1'b0);
    chk("brpl_taken_pc", pc_m, 32'h7E);
`ifdef BRANCH_STATS_EN
    chk("stats_taken", {29'd0, taken_cnt}, 32'd3);
    chk("stats_not_taken", {29'd0, not_taken_cnt}, 32'd2);
`endif

    // Non-branch: executor handshake
    ir = 32'h1800_0000;
    step(E_T0, "ex_t0");
    fetch(0);
    step(E_EX, "exec_enter");
    for (int i = 0; i < 4; i++) step(E_EX, "exec_hold");
    exec_done = 1'b1;
    step(E_T0, "exec_done_t0");
    exec_done = 1'b0;
    fetch(0);
    step(E_EX, "exec_enter2");
    run = 1'b0; exec_done = 1'b1;
    step(E_IDLE, "exec_to_idle");
    step(E_IDLE, "done_ignored_idle");
    exec_done = 1'b0;

    // clr during T4 aborts the branch
    ir = 32'h9100_0023; r2_m = 32'd0; run = 1'b1;
    step(E_T0, "abort_t0");
    fetch(0);
    step(E_T3, "abort_t3");
    step(E_T4, "abort_t4");
    clr = 1'b1;
    #1 chk("clr_t4_outs", {14'd0, outv}, 32'd0);
    step(E_IDLE, "clr_t4_idle");
    clr = 1'b0; run = 1'b0;
    step(E_IDLE, "post_clr_idle");
    chk("abort_pc", pc_m, 32'h81);
`ifdef BRANCH_STATS_EN
    chk("stats_clr_taken", {29'd0, taken_cnt}, 32'd0);
    chk("stats_clr_nt", {29'd0, not_taken_cnt}, 32'd0);
    run = 1'b1;
    step(E_T0, "sat_t0");
    for (int k = 0; k < 10; k++) begin
      fetch(0);
      branch(1'b1, k != 9);
    end
    chk("stats_sat_taken", {29'd0, taken_cnt}, 32'd7);
    chk("stats_sat_nt", {29'd0, not_taken_cnt}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
